// File: rtl/memory_access_stage_if.sv
// Data-memory bus between memory_access_stage (master) and the data memory (slave).
// A request transfers on a posedge where dmem_req_valid && dmem_req_ready. While valid waits for
// ready, the master keeps we/addr/be/wdata stable. dmem_resp_valid carries load data and has no ready.
interface memory_access_stage_if #(
  parameter int XLEN = 32
);
  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [3:0]      dmem_be;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_resp_valid;
  logic [XLEN-1:0] dmem_resp_rdata;

  modport master (
    output dmem_req_valid, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
  );
endinterface

// File: rtl/memory_access_stage.sv
// Memory stage: issues data-memory loads/stores, formats load data and builds the rd write-back.
// Defining MEM_MISALIGN_CHECK_EN turns misaligned half/word accesses into request-less, non-writing ops.
module memory_access_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_addr,
  input  logic [XLEN-1:0]       in_wdata,
  input  logic [1:0]            in_width,
  input  logic                  in_is_load,
  input  logic                  in_is_store,
  input  logic                  in_is_load_unsigned,
  input  logic                  in_rd_wen,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic                  in_is_forwardable,
  input  logic [XLEN-1:0]       in_rd_wdata,
  memory_access_stage_if.master dmem,
  output logic                  mem_busy,
  output logic [XLEN-1:0]       out_pc,
  output logic                  out_rd_wen,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic [XLEN-1:0]       out_rd_wdata,
  output logic                  out_is_forwardable,
  output logic                  out_misaligned,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, DONE = 2'd3} state_t;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       addr;
    logic [XLEN-1:0]       wdata;
    logic [1:0]            width;
    logic                  is_load;
    logic                  is_store;
    logic                  is_load_unsigned;
    logic                  rd_wen;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  is_forwardable;
    logic [XLEN-1:0]       rd_wdata;
  } pipe_t;

  pipe_t           pipe;
  state_t          state;
  logic [XLEN-1:0] load_buf;
  logic            memop;
  logic            misaligned;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_fmt;

  assign memop    = pipe.is_load | pipe.is_store;
  assign mem_busy = memop && (state != DONE);

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = memop && ((pipe.width == 2'd1) ? pipe.addr[0] :
                                (pipe.width != 2'd0) ? (|pipe.addr[1:0]) : 1'b0);
`else
  assign misaligned = 1'b0;
`endif

  // A busy stage owns its instruction: neither flush nor a new capture may disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
    end else if (!mem_busy) begin
      if (flush) begin
        pipe <= '0;
      end else if (!stall) begin
        pipe <= '{pc: in_pc, addr: in_addr, wdata: in_wdata, width: in_width,
                  is_load: in_is_load, is_store: in_is_store,
                  is_load_unsigned: in_is_load_unsigned, rd_wen: in_rd_wen,
                  rd_addr: in_rd_addr, is_forwardable: in_is_forwardable,
                  rd_wdata: in_rd_wdata};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      load_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memop) begin
            if (misaligned)               state <= DONE;
            else if (dmem.dmem_req_ready) state <= pipe.is_store ? DONE : RESP;
            else                          state <= REQ;
          end
        end
        REQ: begin
          if (dmem.dmem_req_ready) state <= pipe.is_store ? DONE : RESP;
        end
        RESP: begin
          if (dmem.dmem_resp_valid) begin
            load_buf <= load_fmt;
            state    <= DONE;
          end
        end
        DONE: begin
          // Leaves when the pipe register takes a new instruction or a bubble.
          if (flush || !stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ld_byte = dmem.dmem_resp_rdata[{pipe.addr[1:0], 3'b000} +: 8];
  assign ld_half = dmem.dmem_resp_rdata[{pipe.addr[1], 4'b0000} +: 16];

  always_comb begin
    load_fmt = dmem.dmem_resp_rdata;
    case (pipe.width)
      2'd0:    load_fmt = {{(XLEN-8){~pipe.is_load_unsigned & ld_byte[7]}}, ld_byte};
      2'd1:    load_fmt = {{(XLEN-16){~pipe.is_load_unsigned & ld_half[15]}}, ld_half};
      default: load_fmt = dmem.dmem_resp_rdata;
    endcase
  end

  assign dmem.dmem_req_valid = memop && !misaligned && ((state == IDLE) || (state == REQ));
  assign dmem.dmem_we        = dmem.dmem_req_valid && pipe.is_store;
  assign dmem.dmem_addr      = {pipe.addr[XLEN-1:2], 2'b00};

  always_comb begin
    dmem.dmem_be    = 4'b1111;
    dmem.dmem_wdata = pipe.wdata;
    case (pipe.width)
      2'd0: begin
        dmem.dmem_be    = 4'b0001 << pipe.addr[1:0];
        dmem.dmem_wdata = {4{pipe.wdata[7:0]}};
      end
      2'd1: begin
        dmem.dmem_be    = 4'b0011 << {pipe.addr[1], 1'b0};
        dmem.dmem_wdata = {2{pipe.wdata[15:0]}};
      end
      default: begin
        dmem.dmem_be    = 4'b1111;
        dmem.dmem_wdata = pipe.wdata;
      end
    endcase
    if (!(dmem.dmem_req_valid && pipe.is_store)) dmem.dmem_be = 4'b0000;
  end

  assign out_pc             = pipe.pc;
  assign out_rd_addr        = pipe.rd_addr;
  assign out_is_forwardable = pipe.is_forwardable;
  assign out_rd_wdata       = pipe.is_load ? load_buf : pipe.rd_wdata;
  assign out_rd_wen         = pipe.rd_wen && !mem_busy && !misaligned;
  assign out_misaligned     = misaligned;
  assign dbg_state          = state;

endmodule
